raster_timing_ctl: RTL and testbench

Parametrised raster timing and fetch-scheduling engine for the SAM Coupe video path, generalising the fixed 384×312 counter, blanking/sync generator, fetch window and interrupt logic into one reusable block. It adds programmable frame geometry, `NUM_LINE_IRQ` independent line-interrupt comparators with sticky, acknowledgeable status, and frame-boundary latching of mode/page. It sits between the CPU port decoder and the pixel shifter/VRAM address logic.

---
 rtl/raster_timing_ctl.sv | 175 +++++++++++++++++
 tb/tb_raster_timing_ctl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_timing_ctl.sv
// Raster timing and fetch scheduler for the SAM Coupe video path: programmable
// frame geometry, blank/sync, fetch window, line/frame interrupts and CPU contention.
module raster_timing_ctl #(
    parameter int H_TOTAL      = 384,
    parameter int V_TOTAL      = 312,
    parameter int H_ACT        = 128,
    parameter int V_ACT        = 192,
    parameter int HB_ON        = 28,
    parameter int HS_ON        = 44,
    parameter int HS_OFF       = 76,
    parameter int HB_OFF       = 108,
    parameter int VB_ON        = 236,
    parameter int VB_OFF       = 260,
    parameter int VS_ON        = 240,
    parameter int VS_OFF       = 244,
    parameter int INT_LEN      = 128,
    parameter int CPU_SLOT     = 5,
    parameter int NUM_LINE_IRQ = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ce_6mp,
    input  logic                    ce_6mn,
    input  logic                    soff,
    input  logic                    full_zx,
    input  logic [1:0]              mode_in,
    input  logic [4:0]              page_in,
    input  logic                    cmp_we,
    input  logic [1:0]              cmp_sel,
    input  logic [7:0]              cmp_din,
    input  logic [NUM_LINE_IRQ-1:0] ack,
    output logic [8:0]              hc,
    output logic [8:0]              vc,
    output logic                    hblank,
    output logic                    hsync,
    output logic                    vblank,
    output logic                    vsync,
    output logic                    fetch,
    output logic [1:0]              mode,
    output logic [4:0]              page,
    output logic                    flash,
    output logic [NUM_LINE_IRQ-1:0] int_line,
    output logic                    int_frame,
    output logic [NUM_LINE_IRQ-1:0] irq_status,
    output logic                    mem_contention,
    output logic                    io_contention
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // All raster compares run on the 9-bit zero-extended counters.
    localparam logic [8:0] H_ACT_P   = 9'(H_ACT);
    localparam logic [8:0] V_ACT_P   = 9'(V_ACT);
    localparam logic [8:0] HB_ON_P   = 9'(HB_ON);
    localparam logic [8:0] HS_ON_P   = 9'(HS_ON);
    localparam logic [8:0] HS_OFF_P  = 9'(HS_OFF);
    localparam logic [8:0] HB_OFF_P  = 9'(HB_OFF);
    localparam logic [8:0] VB_ON_P   = 9'(VB_ON);
    localparam logic [8:0] VB_OFF_P  = 9'(VB_OFF);
    localparam logic [8:0] VS_ON_P   = 9'(VS_ON);
    localparam logic [8:0] VS_OFF_P  = 9'(VS_OFF);
    localparam logic [8:0] INT_LEN_P = 9'(INT_LEN);
    localparam logic [2:0] SLOT_P    = 3'(CPU_SLOT);

    logic [HW-1:0]           hc_q;
    logic [VW-1:0]           vc_q;
    logic [4:0]              flash_cnt;
    logic [7:0]              cmp_q [NUM_LINE_IRQ];
    logic [NUM_LINE_IRQ-1:0] int_line_d;

    assign hc    = 9'(hc_q);
    assign vc    = 9'(vc_q);
    assign flash = flash_cnt[4];

    // Raster counters; mode/page and the flash counter advance only on the frame wrap.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hc_q      <= '0;
            vc_q      <= '0;
            flash_cnt <= '0;
            mode      <= '0;
            page      <= '0;
        end else if (ce_6mp) begin
            if (hc_q == H_LAST) begin
                hc_q <= '0;
                if (vc_q == V_LAST) begin
                    vc_q      <= '0;
                    flash_cnt <= flash_cnt + 5'd1;
                    mode      <= mode_in;
                    page      <= page_in;
                end else begin
                    vc_q <= vc_q + VW'(1);
                end
            end else begin
                hc_q <= hc_q + HW'(1);
            end
        end
    end

    // Blank/sync/fetch/interrupt outputs, registered half a pixel after the counters.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hblank    <= 1'b0;
            hsync     <= 1'b0;
            vblank    <= 1'b0;
            vsync     <= 1'b0;
            fetch     <= 1'b0;
            int_frame <= 1'b0;
            int_line  <= '0;
        end else if (ce_6mn) begin
            if (hc == HB_ON_P)       hblank <= 1'b1;
            else if (hc == HB_OFF_P) hblank <= 1'b0;

            if (hc == HS_ON_P)       hsync <= 1'b1;
            else if (hc == HS_OFF_P) hsync <= 1'b0;

            // Vertical edges are taken once per line at a fixed horizontal point.
            if (hc == HB_OFF_P) begin
                if (vc == VB_ON_P)       vblank <= 1'b1;
                else if (vc == VB_OFF_P) vblank <= 1'b0;
            end
            if (hc == 9'd0) begin
                if (vc == VS_ON_P)       vsync <= 1'b1;
                else if (vc == VS_OFF_P) vsync <= 1'b0;
            end

            if (hc == 9'd0)
                fetch <= 1'b0;
            else if (hc >= H_ACT_P && vc < V_ACT_P && hc[2:0] == 3'd0)
                fetch <= ~soff;

            int_frame <= (vc == VS_OFF_P) && (hc < INT_LEN_P);
            for (int i = 0; i < NUM_LINE_IRQ; i++) begin
                int_line[i] <= ({1'b0, cmp_q[i]} < V_ACT_P) &&
                               (cmp_q[i] == vc[7:0]) && (hc < INT_LEN_P);
            end
        end
    end

    // Sticky status: a new rising edge outranks a simultaneous acknowledge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            int_line_d <= '0;
            irq_status <= '0;
        end else begin
            int_line_d <= int_line;
            irq_status <= (irq_status & ~ack) | (int_line & ~int_line_d);
        end
    end

    // NOTE: the compare bank is a small register array, not RAM, so it can take
    // the async reset; 8'hFF leaves every comparator disabled out of reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINE_IRQ; i++) cmp_q[i] <= 8'hFF;
        end else if (cmp_we) begin
            for (int i = 0; i < NUM_LINE_IRQ; i++) begin
                if (cmp_sel == 2'(i)) cmp_q[i] <= cmp_din;
            end
        end
    end

    // CPU gets one slot in eight during fetch or ZX-style contention, else one in four.
    assign io_contention  = hc[2:0] != SLOT_P;
    assign mem_contention = (fetch || (mode == 2'd0 && !full_zx && hc[6]))
                            ? (hc[2:0] != SLOT_P)
                            : (hc[1:0] != SLOT_P[1:0]);

endmodule

// File: tb/tb_raster_timing_ctl.sv
// Directed bench for raster_timing_ctl: a reduced-geometry instance exercises full
// frames cheaply; a default-geometry instance checks reset, the 383 wrap and hsync.
module tb_raster_timing_ctl;

    localparam int HT = 136;
    localparam int VT = 10;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ce_6mp, ce_6mn, soff, full_zx, cmp_we;
    logic [1:0] mode_in, cmp_sel, ack;
    logic [4:0] page_in;
    logic [7:0] cmp_din;

    logic [8:0] hc, vc;
    logic       hblank, hsync, vblank, vsync, fetch, flash, int_frame;
    logic       mem_contention, io_contention;
    logic [1:0] mode, int_line, irq_status;
    logic [4:0] page;

    logic [8:0] d_hc, d_vc;
    logic       d_hblank, d_hsync, d_vblank, d_vsync, d_fetch, d_flash, d_int_frame;
    logic       d_mem_contention, d_io_contention;
    logic [1:0] d_mode, d_int_line, d_irq_status;
    logic [4:0] d_page;

    int n_checks = 0;
    int n_pass   = 0;
    int m_h      = 0;
    int m_v      = 0;
    int m_frames = 0;
    bit l0_seen, l1_v2, l1_other;

    raster_timing_ctl #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT(128), .V_ACT(6),
        .HB_ON(28), .HS_ON(44), .HS_OFF(76), .HB_OFF(108),
        .VB_ON(6), .VB_OFF(9), .VS_ON(7), .VS_OFF(8),
        .INT_LEN(128), .CPU_SLOT(5), .NUM_LINE_IRQ(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_6mp(ce_6mp), .ce_6mn(ce_6mn),
        .soff(soff), .full_zx(full_zx), .mode_in(mode_in), .page_in(page_in),
        .cmp_we(cmp_we), .cmp_sel(cmp_sel), .cmp_din(cmp_din), .ack(ack),
        .hc(hc), .vc(vc), .hblank(hblank), .hsync(hsync), .vblank(vblank),
        .vsync(vsync), .fetch(fetch), .mode(mode), .page(page), .flash(flash),
        .int_line(int_line), .int_frame(int_frame), .irq_status(irq_status),
        .mem_contention(mem_contention), .io_contention(io_contention)
    );

    raster_timing_ctl dut_def (
        .clk_sys(clk_sys), .reset(reset), .ce_6mp(ce_6mp), .ce_6mn(ce_6mn),
        .soff(soff), .full_zx(full_zx), .mode_in(mode_in), .page_in(page_in),
        .cmp_we(cmp_we), .cmp_sel(cmp_sel), .cmp_din(cmp_din), .ack(ack),
        .hc(d_hc), .vc(d_vc), .hblank(d_hblank), .hsync(d_hsync), .vblank(d_vblank),
        .vsync(d_vsync), .fetch(d_fetch), .mode(d_mode), .page(d_page), .flash(d_flash),
        .int_line(d_int_line), .int_frame(d_int_frame), .irq_status(d_irq_status),
        .mem_contention(d_mem_contention), .io_contention(d_io_contention)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One pixel: a ce_6mp cycle then a ce_6mn cycle; the model tracks the raster.
    task automatic pixel();
        ce_6mp = 1'b1;
        tick();
        ce_6mp = 1'b0;
        ce_6mn = 1'b1;
        tick();
        ce_6mn = 1'b0;
        if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
                m_v = 0;
                m_frames++;
            end else begin
                m_v++;
            end
        end else begin
            m_h++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int k = 0; k < 2 * HT * VT && !(m_h == h && m_v == v); k++) pixel();
        check($sformatf("hc@%0d,%0d", h, v), 32'(hc), h);
        check($sformatf("vc@%0d,%0d", h, v), 32'(vc), v);
    endtask

    task automatic write_cmp(input logic [1:0] sel, input logic [7:0] din);
        cmp_we  = 1'b1;
        cmp_sel = sel;
        cmp_din = din;
        tick();
        cmp_we  = 1'b0;
    endtask

    task automatic pulse_ack(input logic [1:0] a);
        ack = a;
        tick();
        ack = 2'b00;
    endtask

    initial begin
        reset = 1'b1; ce_6mp = 1'b0; ce_6mn = 1'b0; soff = 1'b0; full_zx = 1'b0;
        mode_in = 2'd0; page_in = 5'd0; cmp_we = 1'b0; cmp_sel = 2'd0;
        cmp_din = 8'd0; ack = 2'b00;
        repeat (3) tick();

        // Reset state
        check("rst_hc", 32'(hc), 0);
        check("rst_vc", 32'(vc), 0);
        check("rst_hsync", 32'(hsync), 0);
        check("rst_vblank", 32'(vblank), 0);
        check("rst_fetch", 32'(fetch), 0);
        check("rst_int_line", 32'(int_line), 0);
        check("rst_irq_status", 32'(irq_status), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_flash", 32'(flash), 0);
        check("rst_io_cont", 32'(io_contention), 1);
        check("def_rst_hc", 32'(d_hc), 0);
        reset = 1'b0;
        repeat (2) tick();
        check("hold_no_ce", 32'(hc), 0);

        // Horizontal sync/blank on line 0
        run_to(43, 0);  check("hsync@43", 32'(hsync), 0);
        pixel();        check("hsync@44", 32'(hsync), 1);
        check("def_hsync@44", 32'(d_hsync), 1);
        run_to(75, 0);  check("hsync@75", 32'(hsync), 1);
        pixel();        check("hsync@76", 32'(hsync), 0);
        run_to(107, 0); check("hblank@107", 32'(hblank), 1);
        pixel();        check("hblank@108", 32'(hblank), 0);

        // Fetch window and fetch contention (8-slot rule)
        run_to(127, 0); check("fetch@127", 32'(fetch), 0);
        pixel();        check("fetch@128", 32'(fetch), 1);
        pixel();        check("mem_cont@129", 32'(mem_contention), 1);
        run_to(133, 0); check("mem_cont@133", 32'(mem_contention), 0);
        check("io_cont@133", 32'(io_contention), 0);
        run_to(135, 0); check("fetch@135", 32'(fetch), 1);
        pixel();        check("fetch@0,1", 32'(fetch), 0);
        check("line_wrap_vc", 32'(vc), 1);

        // Contention outside fetch, mode 0
        run_to(33, 1);  check("mem_cont@33", 32'(mem_contention), 0);
        check("io_cont@33", 32'(io_contention), 1);
        run_to(65, 1);  check("mem_cont@65", 32'(mem_contention), 1);
        full_zx = 1'b1; #1;
        check("mem_cont@65_fullzx", 32'(mem_contention), 0);
        full_zx = 1'b0; #1;
        run_to(69, 1);  check("mem_cont@69", 32'(mem_contention), 0);
        soff = 1'b1;
        run_to(130, 1); check("fetch_soff", 32'(fetch), 0);
        soff = 1'b0;

        // Default geometry: hc wraps after 383
        run_to(111, 2); check("def_hc383", 32'(d_hc), 383);
        check("def_vc0", 32'(d_vc), 0);
        pixel();        check("def_hc_wrap", 32'(d_hc), 0);
        check("def_vc1", 32'(d_vc), 1);

        // Vertical blank/sync, frame interrupt
        run_to(50, 6);  check("vsync@50,6", 32'(vsync), 0);
        check("vblank@50,6", 32'(vblank), 0);
        run_to(120, 6); check("vblank@120,6", 32'(vblank), 1);
        run_to(130, 6); check("fetch_past_vact", 32'(fetch), 0);
        run_to(50, 7);  check("vsync@50,7", 32'(vsync), 1);
        run_to(50, 8);  check("vsync@50,8", 32'(vsync), 0);
        check("int_frame@50,8", 32'(int_frame), 1);
        run_to(130, 8); check("int_frame@130,8", 32'(int_frame), 0);
        run_to(50, 9);  check("vblank@50,9", 32'(vblank), 1);
        run_to(120, 9); check("vblank@120,9", 32'(vblank), 0);
        run_to(135, 9);
        pixel();
        check("frame_wrap_hc", 32'(hc), 0);
        check("frame_wrap_vc", 32'(vc), 0);
        check("flash_f1", 32'(flash), 0);

        // Line interrupts: cmp0=4, cmp1=2; writes happen with no enables
        write_cmp(2'd0, 8'd4);
        write_cmp(2'd1, 8'd2);
        check("hold_during_write", 32'(hc), 0);
        run_to(135, 1); check("int_line@135,1", 32'(int_line), 0);
        pixel();        check("int_line@0,2", 32'(int_line), 2'b10);
        check("status_lag", 32'(irq_status), 2'b00);
        tick();         check("status_set1", 32'(irq_status), 2'b10);
        run_to(127, 2); check("int_line@127,2", 32'(int_line), 2'b10);
        pixel();        check("int_line@128,2", 32'(int_line), 2'b00);
        run_to(0, 4);   check("int_line@0,4", 32'(int_line), 2'b01);
        tick();         check("status_11", 32'(irq_status), 2'b11);
        pulse_ack(2'b01);
        check("status_after_ack", 32'(irq_status), 2'b10);

        // cmp0 >= V_ACT disables; out-of-range select writes nothing
        write_cmp(2'd0, 8'd8);
        write_cmp(2'd3, 8'd4);
        l0_seen = 1'b0; l1_v2 = 1'b0; l1_other = 1'b0;
        for (int k = 0; k < HT * VT; k++) begin
            pixel();
            if (int_line[0]) l0_seen = 1'b1;
            if (int_line[1]) begin
                if (m_v == 2) l1_v2 = 1'b1;
                else          l1_other = 1'b1;
            end
        end
        check("no_line0_irq", 32'(l0_seen), 0);
        check("line1_on_v2", 32'(l1_v2), 1);
        check("line1_elsewhere", 32'(l1_other), 0);
        check("status_no_l0", 32'(irq_status), 2'b10);

        // cmp0 = V_ACT-1 still fires; ack in the set cycle loses
        write_cmp(2'd0, 8'd5);
        pulse_ack(2'b11);
        check("status_cleared", 32'(irq_status), 2'b00);
        run_to(0, 5);   check("int_line@0,5", 32'(int_line), 2'b01);
        ack = 2'b01;
        tick();
        ack = 2'b00;
        check("set_beats_ack", 32'(irq_status), 2'b01);
        pulse_ack(2'b01);
        check("ack_clears", 32'(irq_status), 2'b00);

        // Mode/page latched only at the frame wrap
        run_to(0, 3);
        mode_in = 2'd2;
        page_in = 5'd7;
        run_to(135, 9); check("mode_held", 32'(mode), 0);
        check("page_held", 32'(page), 0);
        pixel();        check("mode_latched", 32'(mode), 2);
        check("page_latched", 32'(page), 7);
        run_to(65, 0);  check("mem_cont_mode2@65", 32'(mem_contention), 0);

        // Flash counter MSB after 16 frames
        for (int k = 0; k < 20 * HT * VT && !(m_frames == 15 && m_h == HT - 1 && m_v == VT - 1); k++)
            pixel();
        check("flash_pre16_vc", 32'(vc), VT - 1);
        check("flash_pre16", 32'(flash), 0);
        pixel();        check("flash_16", 32'(flash), 1);

        // Asynchronous reset in the middle of a line
        run_to(50, 7);
        check("pre_rst_hsync", 32'(hsync), 1);
        check("pre_rst_vsync", 32'(vsync), 1);
        check("pre_rst_vblank", 32'(vblank), 1);
        check("pre_rst_status", 32'(irq_status), 2'b11);
        #3;
        reset = 1'b1;
        #1;
        check("arst_hc", 32'(hc), 0);
        check("arst_vc", 32'(vc), 0);
        check("arst_hsync", 32'(hsync), 0);
        check("arst_hblank", 32'(hblank), 0);
        check("arst_vsync", 32'(vsync), 0);
        check("arst_vblank", 32'(vblank), 0);
        check("arst_mode", 32'(mode), 0);
        check("arst_page", 32'(page), 0);
        check("arst_flash", 32'(flash), 0);
        check("arst_status", 32'(irq_status), 0);
        check("arst_def_hc", 32'(d_hc), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
